// File: rtl/fifo_read_gray_ctrl.sv
// Read-domain pointer and output stage of the dual-clock FIFO.
// Tracks the tail pointer, detects empty against the synced write Gray pointer, and
// feeds a 2-entry first-word-fall-through buffer from a 1-cycle-latency BRAM.
module fifo_read_gray_ctrl #(
  parameter int INT_FIFO_PTR_BITS_CNT = 32,
  parameter int DATA_WIDTH            = 32
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  output logic                           read_en,
  output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_rd_intptr,
  input  logic [DATA_WIDTH-1:0]          i_rd_data,
  output logic [INT_FIFO_PTR_BITS_CNT:0] o_rd_grayptr,
  input  logic [INT_FIFO_PTR_BITS_CNT:0] i_wr_grayptr,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_empty
);

  localparam int PW = INT_FIFO_PTR_BITS_CNT + 1;

  logic [PW-1:0]         tail, tail_next, tail_gray, gray_next;
  logic [1:0]            occ, occ_after_pop, occ_next;
  logic [2:0]            demand;
  logic                  inflight, pop, empty;
  logic [DATA_WIDTH-1:0] buf0, buf1, buf0_next, buf1_next;

  assign o_valid     = (occ != 2'd0);
  assign o_data      = buf0;
  assign o_empty     = empty;
  assign o_rd_intptr = tail[INT_FIFO_PTR_BITS_CNT-1:0];

  always_comb begin
    tail_gray = tail ^ (tail >> 1);
    empty     = (tail_gray == i_wr_grayptr);
    pop       = o_valid & i_ready;
    // Words held plus the one in flight, after this cycle's pop: never let it exceed 2.
    demand    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    read_en   = ~empty & (demand <= 3'd1);
    tail_next = read_en ? tail + PW'(1) : tail;
    gray_next = tail_next ^ (tail_next >> 1);

    occ_after_pop = occ - {1'b0, pop};
    occ_next      = occ_after_pop + {1'b0, inflight};
    buf0_next     = buf0;
    buf1_next     = buf1;
    if (pop) buf0_next = buf1;
    if (inflight) begin
      if (occ_after_pop == 2'd0) buf0_next = i_rd_data;
      else                       buf1_next = i_rd_data;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      tail         <= '0;
      o_rd_grayptr <= '0;
      occ          <= 2'd0;
      inflight     <= 1'b0;
      buf0         <= '0;
      buf1         <= '0;
    end else begin
      tail         <= tail_next;
      o_rd_grayptr <= gray_next;
      occ          <= occ_next;
      inflight     <= read_en;
      buf0         <= buf0_next;
      buf1         <= buf1_next;
    end
  end

endmodule
